// File: rtl/fetch_responder.sv
// fetch_responder -- memory-side responder for the prefetch request interface.
//
// Serves up to three operand bytes at if_adr_i and the opcode byte at
// inst_adr_i from a DEPTH-byte window buffer (DEPTH = 2**WIN_BITS). The window
// is filled a byte at a time over an external req/ack bus. A one-byte opcode
// hold register covers far opcode peeks without disturbing the window.
//
// Optional build macro: FRESP_STATS_EN adds the stat_miss_o / stat_stl_o
// saturating counters. Without it those ports do not exist.
//
// Ports:
//   clk_i        clock, rising edge
//   rst_n_i      asynchronous active-low reset
//   if_adr_i     operand fetch start address
//   if_cnt_i     number of operand bytes required (0..3)
//   inst_adr_i   opcode peek address
//   flush_i      invalidate window and opcode hold register
//   stl_o        high while any required byte is missing
//   dat_o        {byte(if_adr+2), byte(if_adr+1), byte(if_adr)}, 0x00 lanes if
//                not required or missing
//   inst_o       byte at inst_adr_i, 0x00 if missing
//   ext_req_o    external read request
//   ext_adr_o    external read address
//   ext_ack_i    external acknowledge, data valid in the same cycle
//   ext_dat_i    external read data
//   stat_miss_o  (FRESP_STATS_EN) count of refill starts, saturating
//   stat_stl_o   (FRESP_STATS_EN) count of stalled cycles, saturating
module fetch_responder #(
  parameter int WIN_BITS = 4
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [15:0] if_adr_i,
  input  logic [1:0]  if_cnt_i,
  input  logic [15:0] inst_adr_i,
  input  logic        flush_i,
  output logic        stl_o,
  output logic [23:0] dat_o,
  output logic [7:0]  inst_o,
  output logic        ext_req_o,
  output logic [15:0] ext_adr_o,
  input  logic        ext_ack_i,
  input  logic [7:0]  ext_dat_i
`ifdef FRESP_STATS_EN
  ,
  output logic [15:0] stat_miss_o,
  output logic [15:0] stat_stl_o
`endif
);

  localparam int          DEPTH    = 1 << WIN_BITS;
  localparam logic [15:0] DEPTH16  = 16'(DEPTH);
  localparam logic [15:0] SPAN16   = 16'(DEPTH - 3);
  localparam logic [WIN_BITS-1:0] IDX_LAST = WIN_BITS'(DEPTH - 1);

  typedef enum logic [1:0] {IDLE, FILL, HOLD} state_t;

  state_t              state_q, state_d;
  logic [15:0]         base_q, base_d;
  logic [WIN_BITS-1:0] idx_q, idx_d;
  logic [DEPTH-1:0]    vld_q, vld_d;
  logic [15:0]         hold_tag_q, hold_tag_d;
  logic                hold_vld_q, hold_vld_d;
  logic                redir_q, redir_d;
  logic                flpend_q, flpend_d;
  logic [7:0]          mem_q [DEPTH];
  logic [7:0]          hold_dat_q;
  logic                win_we, hold_we;

  // Lookup lanes 0..2 are operand bytes, lane 3 is the opcode byte.
  logic [15:0] look_adr [4];
  logic [15:0] look_off [4];
  logic [7:0]  look_dat [4];
  logic [3:0]  look_hit;
  logic [3:0]  in_win;
  logic [2:0]  need_ops;
  logic        op_miss, inst_miss, redirect;

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      look_adr[k] = (k == 3) ? inst_adr_i : 16'(if_adr_i + 16'(k));
      // Modulo-2^16 distance from the window base; wraps naturally.
      look_off[k] = 16'(look_adr[k] - base_q);
      in_win[k]   = look_off[k] < DEPTH16;
      look_hit[k] = 1'b0;
      look_dat[k] = 8'h00;
      if (in_win[k] && vld_q[look_off[k][WIN_BITS-1:0]]) begin
        look_hit[k] = 1'b1;
        look_dat[k] = mem_q[look_off[k][WIN_BITS-1:0]];
      end else if (hold_vld_q && (hold_tag_q == look_adr[k])) begin
        look_hit[k] = 1'b1;
        look_dat[k] = hold_dat_q;
      end
    end
  end

  assign need_ops  = {if_cnt_i == 2'd3, if_cnt_i >= 2'd2, if_cnt_i != 2'd0};
  assign op_miss   = |(need_ops & ~look_hit[2:0]);
  assign inst_miss = ~look_hit[3];
  // An operand that can never arrive from the current window (and is not
  // covered by the hold register) makes the running fill pointless.
  assign redirect  = |(need_ops & ~in_win[2:0] & ~look_hit[2:0]);

  assign stl_o  = op_miss | inst_miss;
  assign dat_o  = {need_ops[2] ? look_dat[2] : 8'h00,
                   need_ops[1] ? look_dat[1] : 8'h00,
                   need_ops[0] ? look_dat[0] : 8'h00};
  assign inst_o = look_dat[3];

  assign ext_req_o = (state_q != IDLE);
  assign ext_adr_o = (state_q == FILL) ? 16'(base_q + 16'(idx_q)) :
                     (state_q == HOLD) ? hold_tag_q : 16'h0000;

  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    idx_d      = idx_q;
    vld_d      = vld_q;
    hold_tag_d = hold_tag_q;
    hold_vld_d = hold_vld_q;
    redir_d    = redir_q;
    flpend_d   = flpend_q;
    win_we     = 1'b0;
    hold_we    = 1'b0;
    unique case (state_q)
      IDLE: begin
        // A flush cycle only invalidates; the next cycle re-evaluates.
        if (!flush_i) begin
          if (op_miss) begin
            // Anchor the window on the opcode when the operands still fit
            // behind it, so one fill covers both.
            base_d   = (16'(if_adr_i - inst_adr_i) <= SPAN16) ? inst_adr_i : if_adr_i;
            idx_d    = '0;
            vld_d    = '0;
            redir_d  = 1'b0;
            flpend_d = 1'b0;
            state_d  = FILL;
          end else if (inst_miss) begin
            hold_tag_d = inst_adr_i;
            hold_vld_d = 1'b0;
            redir_d    = 1'b0;
            flpend_d   = 1'b0;
            state_d    = HOLD;
          end
        end
      end
      FILL: begin
        if (redirect) redir_d = 1'b1;
        if (flush_i)  flpend_d = 1'b1;
        if (ext_ack_i) begin
          win_we = !(flush_i || flpend_q);
          idx_d  = idx_q + WIN_BITS'(1);
          if ((idx_q == IDX_LAST) || redirect || redir_q || flush_i || flpend_q)
            state_d = IDLE;
        end
      end
      HOLD: begin
        if (flush_i) flpend_d = 1'b1;
        if (ext_ack_i) begin
          hold_we = !(flush_i || flpend_q);
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (win_we)  vld_d[idx_q] = 1'b1;
    if (hold_we) hold_vld_d   = 1'b1;
    if (flush_i) begin
      vld_d      = '0;
      hold_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= IDLE;
      base_q     <= '0;
      idx_q      <= '0;
      vld_q      <= '0;
      hold_tag_q <= '0;
      hold_vld_q <= 1'b0;
      redir_q    <= 1'b0;
      flpend_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      idx_q      <= idx_d;
      vld_q      <= vld_d;
      hold_tag_q <= hold_tag_d;
      hold_vld_q <= hold_vld_d;
      redir_q    <= redir_d;
      flpend_q   <= flpend_d;
    end
  end

  // Data storage carries no reset; every read is qualified by a valid bit.
  always_ff @(posedge clk_i) begin
    if (win_we)  mem_q[idx_q] <= ext_dat_i;
    if (hold_we) hold_dat_q   <= ext_dat_i;
  end

`ifdef FRESP_STATS_EN
  logic [15:0] stat_miss_q, stat_stl_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      stat_miss_q <= '0;
      stat_stl_q  <= '0;
    end else begin
      if ((state_q == IDLE) && (state_d != IDLE) && (stat_miss_q != 16'hFFFF))
        stat_miss_q <= stat_miss_q + 16'd1;
      if (stl_o && (stat_stl_q != 16'hFFFF))
        stat_stl_q <= stat_stl_q + 16'd1;
    end
  end

  assign stat_miss_o = stat_miss_q;
  assign stat_stl_o  = stat_stl_q;
`endif

endmodule

// File: doc/fetch_responder.md
Name: fetch_responder

Overview:
- Memory-side responder for the prefetch request interface. The prefetch stage presents a fetch address, a byte count and an instruction-peek address every cycle, and samples the returned data whenever stall is low.
- This block returns up to 3 operand bytes plus the opcode byte at the peek address.
- It serves them from a DEPTH-byte window buffer that it fills over a byte-wide external memory bus with a req/ack handshake.
- It sits between the prefetch stage and the memory/bus fabric.

Parameters:
WIN_BITS, 4, log2 of window depth (DEPTH = 2**WIN_BITS bytes; legal range 3..6).

Ports:
clk_i  in  1  clock; all state changes on the rising edge.
rst_n_i  in  1  reset, asynchronous, active-low.
if_adr_i  in  16  fetch start address from prefetch.
if_cnt_i  in  2  bytes required at if_adr_i (0..3).
inst_adr_i  in  16  opcode peek address.
flush_i  in  1  invalidate window and opcode hold register (after stores or self-modifying code).
stl_o  out  1  high when the required bytes are not all valid.
dat_o  out  24  {byte(if_adr+2), byte(if_adr+1), byte(if_adr)}.
inst_o  out  8  byte at inst_adr_i.
ext_req_o  out  1  external byte read request.
ext_adr_o  out  16  external read address.
ext_ack_i  in  1  external acknowledge; data valid in the same cycle.
ext_dat_i  in  8  external read data.

Behaviour:
- Reset (rst_n_i low, async):
  - State IDLE; all window valid bits 0; base 0.
  - Opcode hold register invalid; ext_req_o 0; ext_adr_o 0.
  - stl_o is 1 throughout reset; dat_o and inst_o read 0x00.
- Required set: bytes if_adr_i+k for k < if_cnt_i, plus byte inst_adr_i. Addresses wrap modulo 2^16 (0xFFFF+1 = 0x0000).
- Window lookup:
  - A byte hits if (a - base) mod 2^16 < DEPTH and its valid bit is set.
  - Otherwise it hits if it matches the opcode hold register (tag + valid).
- stl_o = NOT (all required bytes hit). This is combinational from the inputs and current state, with no extra latency.
- dat_o lanes with k >= if_cnt_i, and any lane that misses, drive 0x00. inst_o drives 0x00 on a miss.
- FSM states: IDLE, FILL, HOLD.
  - IDLE + operand miss:
    - If (if_adr - inst_adr) mod 2^16 <= DEPTH-3, set base = inst_adr_i; otherwise set base = if_adr_i.
    - Clear all valid bits, set fill index 0, go to FILL.
  - IDLE + opcode-only miss: fetch inst_adr_i into the hold register, go to HOLD. The window is untouched, so no thrash is possible.
  - FILL: ext_req_o = 1, ext_adr_o = base + index.
    - On ext_ack_i: write the byte and set its valid bit; index increments.
    - The next request is issued in the following cycle (back-to-back allowed).
    - After byte DEPTH-1 is acked, go to IDLE.
  - HOLD: ext_req_o = 1, ext_adr_o = hold tag. On ack: capture the byte, set valid, go to IDLE.
  - Early restart: stl_o drops as soon as the required bytes are valid, even while FILL continues.
- Handshake rules:
  - ext_req_o and ext_adr_o are held stable until ext_ack_i.
  - An outstanding request is never withdrawn or changed.
  - ext_ack_i is ignored while ext_req_o is 0.
- Redirect during FILL or HOLD (a required operand byte falls outside the current window): finish the outstanding handshake, discard nothing already valid, then return to IDLE, which re-evaluates and restarts.
- flush_i:
  - Clears all valid bits and the hold valid bit in that cycle.
  - If a handshake is outstanding, it completes, but its data is discarded. The FSM then goes to IDLE.
  - flush_i and ext_ack_i in the same cycle: flush wins, and the byte is not marked valid.
- Requests whose inputs change while stl_o=1 are legal. Hit/miss is re-evaluated every cycle.

Optional Feature:
- Macro FRESP_STATS_EN.
- When defined, adds outputs stat_miss_o[15:0] and stat_stl_o[15:0]:
  - stat_miss_o counts IDLE-to-FILL/HOLD transitions.
  - stat_stl_o counts cycles with stl_o=1 after reset release.
  - Both saturate at 0xFFFF and are cleared by reset only.
- When undefined, these ports and counters do not exist and behaviour is otherwise identical.

Test Plan:
- Cold start: release reset with if_adr=0xFFFC, cnt=3, inst_adr=0xFFFC, ext_ack one cycle after each req.
  - Required: ext_adr sequence FFFC, FFFD, FFFE, FFFF, 0000…; stl_o falls the cycle after the FFFE ack.
  - Required: dat_o = {m[FFFE], m[FFFD], m[FFFC]}.
- Sequential hits: after the window fills at base 0x0200, step if_adr 0x0200 → 0x0203 → 0x0205 with cnt 3/2/1.
  - Required: stl_o=0 and no ext_req_o.
  - Required: dat_o upper lanes are 0x00 for cnt<3.
- Redirect mid-fill: during FILL at base 0x0200, set if_adr=0x8000 while ack is withheld 3 cycles.
  - Required: ext_adr stays 0x020x until ack, then FILL restarts at 0x8000.
- Far opcode peek: if_adr=0x1000 valid, inst_adr=0x4000.
  - Required: HOLD fetch of 0x4000 only, window unchanged, then inst_o = m[0x4000] and stl_o=0.
- Flush with ack: assert flush_i in the same cycle as ext_ack_i.
  - Required: the byte is not valid, stl_o=1, and refetch starts from a new FILL.
- Async reset mid-FILL: drop rst_n_i between clock edges.
  - Required: ext_req_o=0 and stl_o=1 immediately.
  - Required (with FRESP_STATS_EN): counters read 0.
